// File: rtl/ei_rate_generator_pkg.sv
// rtl/ei_rate_generator_pkg.sv - shared types and constants for the ei rate generator
// Purpose: FSM state encoding, default widths and the free-run wrap constant.
package ei_rate_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DIV_W_DEF      = 8;
  localparam int WRAP_W_DEF     = 4;
  // A wrap count of zero means run until stopped.
  localparam int WRAPS_FREE_RUN = 0;

endpackage

// File: rtl/ei_rate_generator_prescaler.sv
// rtl/ei_rate_generator_prescaler.sv - reloadable down-counter producing the ei tick
// Purpose: counts D, D-1, ..., 0 and reloads D after 0, giving a period of D+1.
// Ports:
//   m_clock, m_reset_ : clock, synchronous active-low reset
//   load_i            : force cnt to div_i (takes priority over run_i)
//   run_i             : advance the counter
//   div_i             : reload value D
//   tick_o            : high while cnt == 0
module ei_prescaler
  import ei_rate_generator_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             m_clock,
  input  logic             m_reset_,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge m_clock) begin
    if (!m_reset_) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= div_i;
    end else if (run_i) begin
      // Reload at zero, so the counter never wraps below zero.
      cnt_q <= (cnt_q == '0) ? div_i : cnt_q - DIV_W'(1);
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/ei_rate_generator.sv
// rtl/ei_rate_generator.sv - programmable ei pulse source with carry-based completion
// Purpose: loads divisor D and wrap count K over a dav_/rfd handshake, then pulses
//   ei every D+1 cycles until K carries (m_eu) are seen, or m_stop arrives.
// Ports:
//   m_clock, m_reset_     : clock, synchronous active-low reset
//   m_dav_                : producer data-available, active-low
//   m_divisor, m_wraps    : D and K, sampled when the transfer is accepted
//   m_stop                : abort request, honoured in RUN only
//   m_eu                  : carry-out of the downstream counter
//   rfd, ei, busy, done   : Moore outputs decoded from state (and cnt for ei)
module ei_rate_generator
  import ei_rate_generator_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              m_clock,
  input  logic              m_reset_,
  input  logic              m_dav_,
  input  logic [DIV_W-1:0]  m_divisor,
  input  logic [WRAP_W-1:0] m_wraps,
  input  logic              m_stop,
  input  logic              m_eu,
  output logic              rfd,
  output logic              ei,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [DIV_W-1:0]  d_q;
  logic [WRAP_W-1:0] w_q;
  logic              f_q;
  // Set once dav_ has been seen high in IDLE; a transfer needs a fresh 1->0 edge.
  logic              armed_q;

  logic             start;
  logic             tick;
  logic             carry;
  logic [DIV_W-1:0] pre_div;

  assign start   = (state_q == ST_IDLE) && armed_q && !m_dav_;
  // On the accepting edge D is not yet in d_q, so load straight from the input.
  assign pre_div = start ? m_divisor : d_q;

  ei_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .m_clock (m_clock),
    .m_reset_(m_reset_),
    .load_i  (start),
    .run_i   (state_q == ST_RUN),
    .div_i   (pre_div),
    .tick_o  (tick)
  );

  assign ei    = (state_q == ST_RUN) && tick;
  // Carries only count when this block itself issued the enable.
  assign carry = ei && m_eu && f_q;

  always_ff @(posedge m_clock) begin
    if (!m_reset_) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      w_q     <= '0;
      f_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m_dav_) armed_q <= 1'b1;
          if (start) begin
            state_q <= ST_ACK;
            d_q     <= m_divisor;
            w_q     <= m_wraps;
            f_q     <= (m_wraps != WRAP_W'(WRAPS_FREE_RUN));
            armed_q <= 1'b0;
          end
        end
        ST_ACK: begin
          if (m_dav_) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (carry) w_q <= w_q - WRAP_W'(1);
          // Completion is decided at W==1, so W never wraps through zero.
          if (m_stop || (carry && (w_q == WRAP_W'(1)))) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rfd  = (state_q == ST_IDLE);
  assign busy = (state_q == ST_ACK) || (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ei_rate_generator.sv
// tb/tb_ei_rate_generator.sv - self-checking bench for ei_rate_generator
module tb_ei_rate_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dav_n = 1'b1;
  logic [7:0] divisor = '0;
  logic [3:0] wraps = '0;
  logic       stop = 1'b0;
  logic       eu_force = 1'b0;
  logic       eu;
  logic       rfd, ei, busy, done;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  int ei_total = 0;
  int done_total = 0;

  always #5 clk = ~clk;

  ei_rate_generator dut (
    .m_clock  (clk),
    .m_reset_ (rst_n),
    .m_dav_   (dav_n),
    .m_divisor(divisor),
    .m_wraps  (wraps),
    .m_stop   (stop),
    .m_eu     (eu),
    .rfd      (rfd),
    .ei       (ei),
    .busy     (busy),
    .done     (done)
  );

  // Downstream 4-bit base-2 counter: counts ei, carries out when enabled at 15.
  logic [3:0] ctr = '0;
  always @(posedge clk) begin
    if (!rst_n) ctr <= '0;
    else if (ei) ctr <= ctr + 4'd1;
  end
  assign eu = eu_force | (ei && (ctr == 4'hF));

  // Behavioural model: phase, RUN-cycle index and carries seen so far.
  int   m_mode = 0;  // 0 idle, 1 ack, 2 run, 3 done
  bit   m_armed = 1'b0;
  int   m_d = 0;
  int   m_k = 0;
  int   m_idx = 0;
  int   m_carries = 0;
  logic exp_ei;
  assign exp_ei = (m_mode == 2) && ((m_idx % (m_d + 1)) == m_d);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_armed <= 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (dav_n) m_armed <= 1'b1;
          if (!dav_n && m_armed) begin
            m_mode  <= 1;
            m_d     <= int'(divisor);
            m_k     <= int'(wraps);
            m_armed <= 1'b0;
          end
        end
        1: if (dav_n) begin
          m_mode    <= 2;
          m_idx     <= 0;
          m_carries <= 0;
        end
        2: begin
          m_idx <= m_idx + 1;
          if (exp_ei && eu) m_carries <= m_carries + 1;
          if (stop || (m_k != 0 && exp_ei && eu && (m_carries + 1 == m_k))) m_mode <= 3;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rfd", 32'(rfd), 32'(m_mode == 0));
      chk("model_busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      chk("model_done", 32'(done), 32'(m_mode == 3));
      chk("model_ei", 32'(ei), 32'(exp_ei));
      if (ei === 1'b1) ei_total++;
      if (done === 1'b1) done_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arming cycle with dav_ high, then dav_ low for hold edges, then release.
  // Returns in the first RUN cycle.
  task automatic load(input int d, input int k, input int hold);
    dav_n = 1'b1;
    tick();
    divisor = 8'(d);
    wraps   = 4'(k);
    dav_n   = 1'b0;
    repeat (hold) tick();
    if (hold == 5) begin
      chk("ack_hold_rfd", 32'(rfd), 32'd0);
      chk("ack_hold_busy", 32'(busy), 32'd1);
      chk("ack_hold_ei", 32'(ei), 32'd0);
    end
    dav_n = 1'b1;
    tick();
  endtask

  int first_ei, min_gap, max_gap, pulses;

  // Counts cycles from the current RUN cycle (numbered start+1) until done.
  task automatic run_until_done(input int start, output int n);
    int last;
    n = start; first_ei = 0; last = 0; min_gap = 1000; max_gap = 0; pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) return;
      if (ei === 1'b1) begin
        pulses++;
        if (first_ei == 0) first_ei = n;
        else begin
          if (n - last < min_gap) min_gap = n - last;
          if (n - last > max_gap) max_gap = n - last;
        end
        last = n;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  int n, d0;

  initial begin
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset_rfd", 32'(rfd), 32'd1);
    chk("reset_ei", 32'(ei), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // D=3, K=1, ACK held for 5 cycles.
    load(3, 1, 5);
    run_until_done(0, n);
    chk("d3_run_cycles", 32'(n - 1), 32'd64);
    chk("d3_pulses", 32'(pulses), 32'd16);
    chk("d3_first_ei", 32'(first_ei), 32'd4);
    chk("d3_min_gap", 32'(min_gap), 32'd4);
    chk("d3_max_gap", 32'(max_gap), 32'd4);
    chk("d3_ctr_back_to_0", 32'(ctr), 32'd0);
    tick();
    chk("d3_rfd_after_done", 32'(rfd), 32'd1);

    // D=0, K=2: ei every RUN cycle.
    d0 = done_total;
    load(0, 2, 1);
    run_until_done(0, n);
    chk("d0_run_cycles", 32'(n - 1), 32'd32);
    chk("d0_pulses", 32'(pulses), 32'd32);
    tick();
    chk("d0_single_done", 32'(done_total - d0), 32'd1);

    // D=2, K=0: free-run, then stop in a pulse cycle.
    d0 = done_total;
    pulses = 0;
    load(2, 0, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ei === 1'b1) pulses++;
    end
    chk("free_pulses_100", 32'(pulses), 32'd33);
    chk("free_no_done", 32'(done_total - d0), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ei === 1'b1) break;
    end
    stop = 1'b1;
    @(negedge clk);
    chk("stop_pulse_kept", 32'(ei), 32'd1);
    tick();
    stop = 1'b0;
    chk("stop_done", 32'(done), 32'd1);
    tick();
    chk("stop_idle", 32'(rfd), 32'd1);

    // Reset mid-RUN with D=5, K=3.
    d0 = done_total;
    load(5, 3, 1);
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_rfd", 32'(rfd), 32'd1);
    chk("midrst_ei", 32'(ei), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Spurious eu while ei=0 must not consume a wrap: K=1 run stays nominal.
    load(1, 1, 1);
    chk("spur_ei_low", 32'(ei), 32'd0);
    eu_force = 1'b1;
    tick();
    eu_force = 1'b0;
    run_until_done(1, n);
    chk("spur_run_cycles", 32'(n - 1), 32'd32);
    tick();
    chk("midrst_one_done_total", 32'(done_total - d0), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
